sorted_stream_stats: RTL and testbench

Downstream consumer of the float merge sorter. It takes the sorter's ascending stream of 32-bit IEEE-754 single words, one accepted word per clock when valid. For each frame of O words it captures min, max, median and count, and checks that the stream really is non-decreasing. Results are held for the control logic under a done/ack handshake.

---
 rtl/sorted_stream_stats.sv | 211 +++++++++++++++++++++
 tb/tb_sorted_stream_stats.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_stream_stats.sv
// sorted_stream_stats: per-frame statistics over the float merge sorter's
// ascending output stream.
//
// Parameters:
//   O   - words per frame (1..255)
//   PAD - sorter padding sentinel (largest positive finite float)
//
// Optional build macro:
//   SORT_STATS_PAD_SKIP_EN - when defined, accepted words equal to PAD are
//                            discarded (not counted, compared or captured).
//
// Ports:
//   clk       - clock, rising edge
//   res       - asynchronous active-low reset
//   in_valid  - in_data carries a sorted word this cycle
//   in_data   - IEEE-754 single from the sorter
//   ack       - consumer has read results (only honoured while done=1)
//   min_val   - first counted word of the frame
//   max_val   - last counted word of the frame
//   med_val   - median word (index O/2 for odd O, O/2-1 for even O)
//   word_cnt  - counted words in the current/last frame
//   order_err - frame contained a descending step
//   overrun   - a word arrived while results were held
//   done      - results valid, waiting for ack
//   busy      - frame in progress

module sorted_stream_stats #(
  parameter int unsigned O   = 7,
  parameter logic [31:0] PAD = 32'h7f7f_ffff
) (
  input  logic        clk,
  input  logic        res,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        ack,
  output logic [31:0] min_val,
  output logic [31:0] max_val,
  output logic [31:0] med_val,
  output logic [7:0]  word_cnt,
  output logic        order_err,
  output logic        overrun,
  output logic        done,
  output logic        busy
);

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 8;
  localparam int unsigned MED = ((O % 2) == 1) ? (O / 2) : ((O / 2) - 1);

  localparam logic [CW-1:0] O_CNT   = CW'(O);
  localparam logic [CW-1:0] MED_CNT = CW'(MED);

`ifdef SORT_STATS_PAD_SKIP_EN
  localparam logic PAD_SKIP = 1'b1;
`else
  localparam logic PAD_SKIP = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DW-1:0] prev;

  logic [DW-1:0] min_nxt;
  logic [DW-1:0] max_nxt;
  logic [DW-1:0] med_nxt;
  logic [DW-1:0] prev_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          oerr_nxt;
  logic          ovr_nxt;
  logic          done_nxt;
  logic          busy_nxt;

  logic          take_c;
  logic          descend_c;
  logic [CW-1:0] cnt_inc_c;

  // Map a float onto an unsigned key that sorts like the sorter does:
  // positives above negatives, negatives with magnitude order inverted.
  function automatic logic [DW-1:0] order_key(input logic [DW-1:0] v);
    return v[31] ? {1'b0, ~v[30:0]} : {1'b1, v[30:0]};
  endfunction

  // Word qualification and comparison against the previous counted word
  always_comb begin
    take_c    = in_valid && (state != HOLD) && !(PAD_SKIP && (in_data == PAD));
    descend_c = order_key(in_data) < order_key(prev);
    cnt_inc_c = CW'(word_cnt + CW'(1));
  end

  // State register
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take_c) begin
          state_nxt = (O_CNT == CW'(1)) ? HOLD : COLLECT;
        end
      end
      COLLECT: begin
        if (take_c && (cnt_inc_c == O_CNT)) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values; results hold unless a word is taken
  always_comb begin
    min_nxt  = min_val;
    max_nxt  = max_val;
    med_nxt  = med_val;
    prev_nxt = prev;
    cnt_nxt  = word_cnt;
    oerr_nxt = order_err;
    ovr_nxt  = overrun;

    case (state)
      IDLE: begin
        if (take_c) begin
          min_nxt  = in_data;
          prev_nxt = in_data;
          cnt_nxt  = CW'(1);
          oerr_nxt = 1'b0;
          ovr_nxt  = 1'b0;
          if (MED_CNT == CW'(0)) begin
            med_nxt = in_data;
          end
          if (O_CNT == CW'(1)) begin
            max_nxt = in_data;
          end
        end
      end
      COLLECT: begin
        if (take_c) begin
          cnt_nxt  = cnt_inc_c;
          prev_nxt = in_data;
          if (descend_c) begin
            oerr_nxt = 1'b1;
          end
          // Pre-increment count is the index of the word being taken
          if (word_cnt == MED_CNT) begin
            med_nxt = in_data;
          end
          if (cnt_inc_c == O_CNT) begin
            max_nxt = in_data;
          end
        end
      end
      HOLD: begin
        // Any arriving word is dropped, even in the ack cycle
        if (in_valid) begin
          ovr_nxt = 1'b1;
        end
      end
      default: begin
        ovr_nxt = overrun;
      end
    endcase

    done_nxt = (state_nxt == HOLD);
    busy_nxt = (state_nxt == COLLECT);
  end

  // Result and status registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      min_val   <= '0;
      max_val   <= '0;
      med_val   <= '0;
      prev      <= '0;
      word_cnt  <= '0;
      order_err <= 1'b0;
      overrun   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      min_val   <= min_nxt;
      max_val   <= max_nxt;
      med_val   <= med_nxt;
      prev      <= prev_nxt;
      word_cnt  <= cnt_nxt;
      order_err <= oerr_nxt;
      overrun   <= ovr_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_sorted_stream_stats.sv
// Bench for sorted_stream_stats: table of frames with hand-entered expected
// statistics, a scoreboard popped on each rising done, and hand-written
// sequences for gaps, overrun, ack corner cases, async reset and padding.

module tb_sorted_stream_stats;

  localparam logic [31:0] PAD = 32'h7f7f_ffff;

  typedef logic [6:0][31:0] frame_t;

  typedef struct {
    frame_t      w;
    logic [31:0] emin;
    logic [31:0] emax;
    logic [31:0] emed;
    logic        eoerr;
  } vec_t;

  typedef struct {
    logic [31:0] min_v;
    logic [31:0] max_v;
    logic [31:0] med_v;
    logic [7:0]  cnt;
    logic        oerr;
  } exp_t;

  logic        clk;
  logic        res;
  logic        in_valid;
  logic [31:0] in_data;
  logic        ack;
  logic [31:0] min_val, max_val, med_val;
  logic [7:0]  word_cnt;
  logic        order_err, overrun, done, busy;

  // Second instance with an even frame size
  logic        v8;
  logic [31:0] d8;
  logic        ack8;
  logic [31:0] min8, max8, med8;
  logic [7:0]  cnt8;
  logic        oerr8, ovr8, done8, busy8;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb_q[$];
  logic done_d = 1'b0;
  vec_t tbl[5];
  logic [31:0] w8[8];

  sorted_stream_stats #(.O(7), .PAD(PAD)) u_dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data), .ack(ack),
    .min_val(min_val), .max_val(max_val), .med_val(med_val), .word_cnt(word_cnt),
    .order_err(order_err), .overrun(overrun), .done(done), .busy(busy)
  );

  sorted_stream_stats #(.O(8), .PAD(PAD)) u_dut8 (
    .clk(clk), .res(res), .in_valid(v8), .in_data(d8), .ack(ack8),
    .min_val(min8), .max_val(max8), .med_val(med8), .word_cnt(cnt8),
    .order_err(oerr8), .overrun(ovr8), .done(done8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t mkf(input logic [31:0] a, b, c, d, e, f, g);
    frame_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f; r[6] = g;
    return r;
  endfunction

  function automatic vec_t mkv(input frame_t w, input logic [31:0] mn, mx, md,
                               input logic oe);
    vec_t v;
    v.w = w; v.emin = mn; v.emax = mx; v.emed = md; v.eoerr = oe;
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.min_v = v.emin; e.max_v = v.emax; e.med_v = v.emed;
    e.cnt = 8'd7; e.oerr = v.eoerr;
    sb_q.push_back(e);
  endtask

  // One accepted word: valid across exactly one rising edge
  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Send words from..6 back to back, then check done rose with 1-cycle latency
  task automatic frame_tail(input vec_t v, input int from);
    for (int i = from; i < 7; i++) send(v.w[i]);
    @(negedge clk);
    chk("done_latency", 32'(done), 32'd1);
    chk("busy_in_hold", 32'(busy), 32'd0);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    @(negedge clk);
    chk("done_after_ack", 32'(done), 32'd0);
    chk("busy_after_ack", 32'(busy), 32'd0);
  endtask

  // Scoreboard: compare held results on every rising edge of done
  always @(negedge clk) begin
    if (done && !done_d) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_min", min_val, e.min_v);
        chk("sb_max", max_val, e.max_v);
        chk("sb_med", med_val, e.med_v);
        chk("sb_cnt", 32'(word_cnt), 32'(e.cnt));
        chk("sb_order_err", 32'(order_err), 32'(e.oerr));
        chk("sb_overrun", 32'(overrun), 32'd0);
      end
    end
    done_d <= done;
  end

  initial begin
    res = 1'b0; in_valid = 1'b0; in_data = '0; ack = 1'b0;
    v8 = 1'b0; d8 = '0; ack8 = 1'b0;

    tbl[0] = mkv(mkf(32'hC0000000, 32'hBF800000, 32'h80000000, 32'h00000000,
                     32'h3F000000, 32'h3F800000, 32'h40000000),
                 32'hC0000000, 32'h40000000, 32'h00000000, 1'b0);
    tbl[1] = mkv(mkf(32'h3F800000, 32'h3F000000, 32'h40000000, 32'h40400000,
                     32'h40800000, 32'h40800000, 32'h40A00000),
                 32'h3F800000, 32'h40A00000, 32'h40400000, 1'b1);
    tbl[2] = mkv(mkf(32'h80000000, 32'hBF800000, 32'h3F800000, 32'h3F800000,
                     32'h3F800000, 32'h3F800000, 32'h3F800000),
                 32'h80000000, 32'h3F800000, 32'h3F800000, 1'b1);
    // +0 followed by -0 is a descending step
    tbl[3] = mkv(mkf(32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000,
                     32'h00000000, 32'h00000000, 32'h00000000),
                 32'h00000000, 32'h00000000, 32'h00000000, 1'b1);
    tbl[4] = mkv(mkf(32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000,
                     32'h40400000, 32'h40400000, 32'h40400000),
                 32'h40400000, 32'h40400000, 32'h40400000, 1'b0);

    w8 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40A00000, 32'h40C00000, 32'h40E00000, PAD};

    // Reset state
    #3;
    chk("rst_min", min_val, 32'd0);
    chk("rst_max", max_val, 32'd0);
    chk("rst_med", med_val, 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_oerr", 32'(order_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    res = 1'b1;

    // ack in IDLE is ignored
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("idle_ack_done", 32'(done), 32'd0);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      push_exp(tbl[i]);
      frame_tail(tbl[i], 0);
      ack_pulse();
    end

    // Overrun while holding, results unchanged, then cleared by a new frame
    push_exp(tbl[1]);
    frame_tail(tbl[1], 0);
    send(32'h3F800000);
    @(negedge clk);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_done", 32'(done), 32'd1);
    chk("ovr_min", min_val, 32'h3F800000);
    chk("ovr_max", max_val, 32'h40A00000);
    chk("ovr_med", med_val, 32'h40400000);
    chk("ovr_cnt", 32'(word_cnt), 32'd7);
    chk("ovr_oerr", 32'(order_err), 32'd1);
    ack_pulse();
    chk("idle_hold_ovr", 32'(overrun), 32'd1);
    chk("idle_hold_max", max_val, 32'h40A00000);
    push_exp(tbl[0]);
    send(tbl[0].w[0]);
    @(negedge clk);
    chk("first_ovr_clr", 32'(overrun), 32'd0);
    chk("first_oerr_clr", 32'(order_err), 32'd0);
    chk("first_cnt", 32'(word_cnt), 32'd1);
    chk("first_busy", 32'(busy), 32'd1);
    chk("first_min", min_val, 32'hC0000000);
    frame_tail(tbl[0], 1);
    ack_pulse();

    // Gap of three invalid cycles between words 2 and 3; ack during COLLECT ignored
    push_exp(tbl[0]);
    send(tbl[0].w[0]);
    send(tbl[0].w[1]);
    ack = 1'b1;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk("gap_cnt", 32'(word_cnt), 32'd2);
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_done", 32'(done), 32'd0);
    end
    ack = 1'b0;
    frame_tail(tbl[0], 2);

    // ack and a dropped word in the same HOLD cycle
    in_valid = 1'b1; in_data = 32'h40000000; ack = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; ack = 1'b0;
    @(negedge clk);
    chk("ackv_done", 32'(done), 32'd0);
    chk("ackv_ovr", 32'(overrun), 32'd1);
    chk("ackv_cnt", 32'(word_cnt), 32'd7);
    chk("ackv_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-frame
    send(tbl[1].w[0]);
    send(tbl[1].w[1]);
    send(tbl[1].w[2]);
    #2;
    res = 1'b0;
    #1;
    chk("arst_min", min_val, 32'd0);
    chk("arst_cnt", 32'(word_cnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_oerr", 32'(order_err), 32'd0);
    chk("arst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    res = 1'b1;
    push_exp(tbl[0]);
    frame_tail(tbl[0], 0);
    ack_pulse();

`ifdef SORT_STATS_PAD_SKIP_EN
    // PAD in IDLE does not start a frame; interleaved PADs are discarded
    send(PAD);
    @(negedge clk);
    chk("pad_idle_busy", 32'(busy), 32'd0);
    chk("pad_idle_min", min_val, 32'hC0000000);
    push_exp(tbl[0]);
    for (int i = 0; i < 6; i++) begin
      send(tbl[0].w[i]);
      send(PAD);
    end
    send(tbl[0].w[6]);
    @(negedge clk);
    chk("pad_done", 32'(done), 32'd1);
    ack_pulse();
`else
    // PAD is an ordinary, last-sorting word
    push_exp(mkv(mkf(32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000,
                     32'h40400000, 32'h40800000, PAD),
                 32'h3F800000, PAD, 32'h40000000, 1'b0));
    frame_tail(mkv(mkf(32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000,
                       32'h40400000, 32'h40800000, PAD),
                   32'h3F800000, PAD, 32'h40000000, 1'b0), 0);
    ack_pulse();

    // Even frame size: median at index 3, PAD last
    for (int i = 0; i < 8; i++) begin
      v8 = 1'b1;
      d8 = w8[i];
      @(posedge clk);
      #1;
      v8 = 1'b0;
    end
    @(negedge clk);
    chk("o8_done", 32'(done8), 32'd1);
    chk("o8_min", min8, 32'h3F800000);
    chk("o8_max", max8, PAD);
    chk("o8_med", med8, 32'h40800000);
    chk("o8_cnt", 32'(cnt8), 32'd8);
    chk("o8_oerr", 32'(oerr8), 32'd0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
